// File: rtl/conv_pkg.sv
// Shared constants and tap indexing for the 5x5 window generator and convolution datapath.
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int KDIM  = 5;
  localparam int WIN_W = PIX_W * KDIM * KDIM;

  // Window tap (r,c) lives at bits [tap_idx(r,c)*PIX_W +: PIX_W]; r=0 oldest line, c=0 oldest column.
  function automatic int tap_idx(input int r, input int c);
    return r * KDIM + c;
  endfunction
endpackage

// File: rtl/line_ram.sv
// Single-port line buffer: combinational read of the old word, write on the clock edge,
// so a read and write to the same address in one cycle returns the previous contents.
module line_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/window_gen_5x5.sv
// 5x5 sliding-window generator over a raster pixel stream, built on four cascaded line buffers.
// Optional frame-alignment checker (frame_err output) enabled by macro WINGEN_ERR_DET_EN.
module window_gen_5x5
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  output logic [WIN_W-1:0]   window,
  output logic               win_valid
`ifdef WINGEN_ERR_DET_EN
  ,output logic              frame_err
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NBUF = KDIM - 1;

  logic [CW-1:0]    col_q, col_d, pos_col;
  logic [RW-1:0]    row_q, row_d, pos_row;
  logic [WIN_W-1:0] window_q, window_d;
  logic             win_valid_q, win_valid_d;
  logic             last_col, last_row;
  logic [PIX_W-1:0] rd_data [NBUF];
  logic [PIX_W-1:0] wr_data [NBUF];
  logic [PIX_W-1:0] col_in  [KDIM];

  // An accepted sof pixel is position (0,0) regardless of where the counters were.
  always_comb begin
    pos_col  = (pix_valid && sof) ? '0 : col_q;
    pos_row  = (pix_valid && sof) ? '0 : row_q;
    last_col = (pos_col == CW'(IMG_WIDTH - 1));
    last_row = (pos_row == RW'(IMG_HEIGHT - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBUF; i++) col_in[i] = rd_data[i];
    col_in[KDIM-1] = pix_in;
    wr_data[NBUF-1] = pix_in;
    for (int i = 0; i < NBUF - 1; i++) wr_data[i] = rd_data[i+1];
  end

  for (genvar g = 0; g < NBUF; g++) begin : g_line
    line_ram #(.DEPTH(IMG_WIDTH)) u_line_ram (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (pos_col),
      .wdata (wr_data[g]),
      .rdata (rd_data[g])
    );
  end

  always_comb begin
    window_d    = window_q;
    win_valid_d = 1'b0;
    if (pix_valid) begin
      for (int r = 0; r < KDIM; r++) begin
        for (int c = 0; c < KDIM - 1; c++) begin
          window_d[tap_idx(r, c)*PIX_W +: PIX_W] = window_q[tap_idx(r, c + 1)*PIX_W +: PIX_W];
        end
        window_d[tap_idx(r, KDIM - 1)*PIX_W +: PIX_W] = col_in[r];
      end
      win_valid_d = (pos_row >= RW'(KDIM - 1)) && (pos_col >= CW'(KDIM - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      window_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      window_q    <= window_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign window    = window_q;
  assign win_valid = win_valid_q;

`ifdef WINGEN_ERR_DET_EN
  logic frame_err_q, frame_err_d;
  logic wrapped_q, wrapped_d;

  // wrapped_q marks that the previous pixel closed a frame, so the next one must carry sof.
  always_comb begin
    frame_err_d = frame_err_q;
    wrapped_d   = wrapped_q;
    if (pix_valid) begin
      if (sof && ((row_q != '0) || (col_q != '0))) frame_err_d = 1'b1;
      if (!sof && wrapped_q) frame_err_d = 1'b1;
      wrapped_d = last_row && last_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_window_gen_5x5.sv
// Randomised self-checking bench for window_gen_5x5 against an image-array reference model.
// Also checks frame_err when built with WINGEN_ERR_DET_EN.
module tb_window_gen_5x5;
  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         sof;
  logic [199:0] window;
  logic         win_valid;
`ifdef WINGEN_ERR_DET_EN
  logic         frame_err;
`endif

  int total = 0;
  int bad   = 0;

  int           mdlRow, mdlCol;
  bit           mdlWrapped, mdlErr;
  logic [7:0]   img [H][W];
  int           pulseCount;
  bit           haveFirst;
  logic [199:0] firstWin, lastWin;

  always #5 clk = ~clk;

  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .window    (window),
    .win_valid (win_valid)
`ifdef WINGEN_ERR_DET_EN
    ,.frame_err(frame_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mdlRow     = 0;
    mdlCol     = 0;
    mdlWrapped = 1'b0;
    mdlErr     = 1'b0;
  endtask

  // Idle gap cycles (with random ignored sof), then one accepted pixel checked one cycle later.
  task automatic applyStimulus(input logic [7:0] pix, input bit s, input int gaps);
    int           pr, pc;
    bit           expValid;
    logic [199:0] expWin;
    for (int g = 0; g < gaps; g++) begin
      pix_valid = 1'b0;
      sof       = 1'($urandom_range(0, 1));
      pix_in    = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("gap_win_valid", 200'(win_valid), 200'd0);
    end
    pr = s ? 0 : mdlRow;
    pc = s ? 0 : mdlCol;
    if (s && (mdlRow != 0 || mdlCol != 0)) mdlErr = 1'b1;
    if (!s && mdlWrapped) mdlErr = 1'b1;
    img[pr][pc] = pix;
    expValid = (pr >= 4) && (pc >= 4);
    expWin   = '0;
    if (expValid) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          expWin[(i*5+j)*8 +: 8] = img[pr-4+i][pc-4+j];
    end
    mdlWrapped = (pr == H - 1) && (pc == W - 1);
    mdlCol     = (pc + 1) % W;
    mdlRow     = (pc == W - 1) ? (pr + 1) % H : pr;

    pix_in    = pix;
    sof       = s;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    checkOutput("win_valid", 200'(win_valid), 200'(expValid));
    if (expValid) checkOutput("window", window, expWin);
    if (win_valid) begin
      pulseCount++;
      if (!haveFirst) firstWin = window;
      haveFirst = 1'b1;
      lastWin   = window;
    end
`ifdef WINGEN_ERR_DET_EN
    checkOutput("frame_err", 200'(frame_err), 200'(mdlErr));
`endif
  endtask

  task automatic sendFrame(input bit pattern, input bit withSof, input int maxGap, input int nPix);
    logic [7:0] pix;
    int         r, c, gaps;
    pulseCount = 0;
    haveFirst  = 1'b0;
    for (int k = 0; k < nPix; k++) begin
      r    = k / W;
      c    = k % W;
      pix  = pattern ? 8'(r * 16 + c) : 8'($urandom);
      gaps = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      applyStimulus(pix, withSof && (k == 0), gaps);
    end
  endtask

  task automatic checkPatternFrame(input string tag);
    checkOutput({tag, "_pulses"}, 200'(pulseCount), 200'd8);
    checkOutput({tag, "_first00"}, 200'(firstWin[7:0]), 200'h00);
    checkOutput({tag, "_first44"}, 200'(firstWin[199:192]), 200'h44);
    checkOutput({tag, "_first22"}, 200'(firstWin[103:96]), 200'h22);
    checkOutput({tag, "_last44"}, 200'(lastWin[199:192]), 200'h57);
    checkOutput({tag, "_last00"}, 200'(lastWin[7:0]), 200'h13);
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = 8'h00;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_window", window, 200'd0);
    checkOutput("reset_win_valid", 200'(win_valid), 200'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed frame, continuous");
    sendFrame(1'b1, 1'b1, 0, W * H);
    checkPatternFrame("cont");

    $display("[TB] directed frame with gaps");
    sendFrame(1'b1, 1'b1, 3, W * H);
    checkPatternFrame("gaps");

    $display("[TB] back-to-back random frames");
    for (int f = 0; f < 2; f++) begin
      sendFrame(1'b0, 1'b1, 2, W * H);
      checkOutput("b2b_pulses", 200'(pulseCount), 200'd8);
    end

    $display("[TB] frame wrap without sof");
    sendFrame(1'b0, 1'b1, 1, W * H);
    sendFrame(1'b0, 1'b0, 1, W * H);
    checkOutput("wrap_pulses", 200'(pulseCount), 200'd8);

    $display("[TB] sof at pixel (2,5)");
    sendFrame(1'b1, 1'b1, 0, 2 * W + 5);
    sendFrame(1'b1, 1'b1, 0, W * H);
    checkPatternFrame("resync");

    $display("[TB] reset mid-frame at pixel (5,3)");
    sendFrame(1'b1, 1'b1, 0, 5 * W + 3);
    pix_in    = 8'h53;
    pix_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_window", window, 200'd0);
    checkOutput("midrst_win_valid", 200'(win_valid), 200'd0);
`ifdef WINGEN_ERR_DET_EN
    checkOutput("midrst_frame_err", 200'(frame_err), 200'd0);
`endif
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
    sendFrame(1'b1, 1'b0, 0, W * H);
    checkPatternFrame("postrst");

    $display("[TB] clean frame after reset");
    sendFrame(1'b0, 1'b1, 3, W * H);
    checkOutput("clean_pulses", 200'(pulseCount), 200'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/window_gen_5x5.md
WINDOW_GEN_5X5 -- requirements
Module: window_gen_5x5

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>=5).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>=5).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pix_in  input  8  grayscale pixel, raster order.
REQ-006 SHALL have port pix_valid  input  1  pix_in accepted on every cycle it is high; no backpressure.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid; marks pixel (0,0).
REQ-008 SHALL have port window  output  200  5x5 neighbourhood; tap (r,c) at bits [(r*5+c)*8 +: 8]; r=0 oldest line, c=0 oldest column; (4,4) = newest pixel.
REQ-009 SHALL have port win_valid  output  1  one-cycle pulse: window holds a complete in-image 5x5 neighbourhood.

Function
REQ-010 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advancing only on accepted pixels.
REQ-011 SHALL wrap col IMG_WIDTH-1 -> 0 with row+1; row IMG_HEIGHT-1 -> 0 on the same wrap.
REQ-012 SHALL treat an accepted pixel with sof=1 as (0,0) whatever the counter values; sof without pix_valid is ignored.
REQ-013 SHALL hold 4 line buffers of IMG_WIDTH x 8 bits, addressed by col, read-before-write, forming a cascade: newest line -> buffer 3 -> ... -> buffer 0.
REQ-014 SHALL, per accepted pixel, shift window columns left by one and load column 4 with {buffer0, buffer1, buffer2, buffer3, pix_in} for rows 0..4.
REQ-015 SHALL update window and win_valid exactly 1 cycle after the accepting edge (latency 1).
REQ-016 SHALL assert win_valid iff the pixel accepted on the previous cycle had row>=4 and col>=4; exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4) pulses per full frame.
REQ-017 SHALL hold window unchanged and win_valid low on cycles with no accepted pixel.
REQ-018 SHALL not clear window or line buffers at line/frame boundaries; stale taps are never exposed because REQ-016 gates them.
REQ-019 SHALL use unsigned 8-bit data throughout; no arithmetic on pixel values.

Reset
REQ-020 SHALL, on rst_n low, force col=0, row=0, window=0, win_valid=0 asynchronously, including mid-frame.
REQ-021 SHALL leave line buffer contents undefined after reset; the first post-reset pixel is treated as (0,0).

Configuration
REQ-022 SHALL honour macro WINGEN_ERR_DET_EN.
REQ-023 SHALL, with WINGEN_ERR_DET_EN defined, add output frame_err (1 bit, reset 0), set sticky when an sof pixel arrives while (row,col) != (0,0) or a non-sof pixel arrives when the wrapped position is (0,0) after a full frame; cleared only by reset.
REQ-024 SHALL, without WINGEN_ERR_DET_EN, omit frame_err and its logic; all other behaviour identical.

Structure
REQ-025 SHALL place PIX_W=8, KDIM=5, WIN_W=200 and the tap-index function (r*KDIM+c) in shared package conv_pkg, used also by the convolution datapath.
REQ-026 SHALL instantiate sub-module line_ram (single-port read-before-write, IMG_WIDTH x 8) four times.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pix_in = row*16+col)
REQ-027 Continuous frame with sof on first pixel -> first win_valid 1 cycle after 37th pixel; window[7:0]=0x00, window[199:192]=0x44, window[103:96]=0x22.
REQ-028 Full frame -> exactly 8 win_valid pulses; last window[199:192]=0x57, window[7:0]=0x13.
REQ-029 Same frame with random 1-3 cycle pix_valid gaps -> identical window sequence, win_valid never high during gaps.
REQ-030 Two back-to-back frames -> second frame emits no win_valid before its pixel (4,4); pulse count again 8.
REQ-031 rst_n low at pixel (5,3) then new frame -> window=0, win_valid=0 immediately; new frame output matches REQ-027.
REQ-032 WINGEN_ERR_DET_EN defined, sof at pixel (2,5) -> frame_err=1 next cycle and stays 1; clean frame from reset -> frame_err stays 0.
